// File: rtl/anton_neopixel_bus_master.sv
// Host-to-responder bus master for the NeoPixel pixel buffer and register file.
// Accepts burst commands from the host and runs them on the responder bus.
// Write bursts return one acknowledge. Read bursts return one response per beat.
// The buffer region wraps at BUFFER_END. The register region wraps within an
// 8-byte block.

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 13'd1535
`endif

module anton_neopixel_bus_master #(
    parameter logic [12:0] BUFFER_END = `BUFFER_END_DEFAULT
) (
    input  logic        busClk_i,
    input  logic        busReset_i,
    input  logic        cmdValid_i,
    output logic        cmdReady_o,
    input  logic        cmdWrite_i,
    input  logic [13:0] cmdAddr_i,
    input  logic [7:0]  cmdData_i,
    input  logic [12:0] cmdLen_i,
    output logic        rspValid_o,
    input  logic        rspReady_i,
    output logic [7:0]  rspData_o,
    output logic        rspLast_o,
    output logic [13:0] busAddr_o,
    output logic [7:0]  busDataIn_o,
    output logic        busWrite_o,
    output logic        busRead_o,
    input  logic [7:0]  busDataOut_i,
    output logic        busy_o
);

    // state   | meaning
    // IDLE    | waiting for a host command, cmdReady high
    // WRITE   | one write strobe per cycle until the beat counter reaches zero
    // READ    | single-cycle read strobe for the current address
    // CAPTURE | responder data is valid, registered into the response
    // RESP    | response held until the host takes it
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_READ    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [12:0] cnt_q, cnt_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_last_q, rsp_last_d;
    logic        cnt_zero;

    // The register region keeps its block and region bits and only steps the
    // byte index. The buffer region wraps only on an exact match with
    // BUFFER_END, so a start address above it just counts up within 13 bits.
    function automatic logic [13:0] next_addr(input logic [13:0] a);
        logic [13:0] n;
        if (a[13]) begin
            n = {a[13:3], a[2:0] + 3'd1};
        end else if (a[12:0] == BUFFER_END) begin
            n = 14'd0;
        end else begin
            n = {1'b0, a[12:0] + 13'd1};
        end
        return n;
    endfunction

    assign cnt_zero = (cnt_q == 13'd0);

    // State register
    always_ff @(posedge busClk_i or posedge busReset_i) begin
        if (busReset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cmdValid_i) state_d = cmdWrite_i ? S_WRITE : S_READ;
            S_WRITE:   if (cnt_zero) state_d = S_RESP;
            S_READ:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_RESP;
            S_RESP:    if (rspReady_i) state_d = rsp_last_q ? S_IDLE : S_READ;
            default:   state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cmdReady_o = 1'b0;
        busy_o     = 1'b1;
        busWrite_o = 1'b0;
        busRead_o  = 1'b0;
        rspValid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmdReady_o = 1'b1;
                busy_o     = 1'b0;
            end
            S_WRITE: busWrite_o = 1'b1;
            S_READ:  busRead_o  = 1'b1;
            S_RESP:  rspValid_o = 1'b1;
            default: ;
        endcase
    end

    // Command latch, address/beat stepping, and response capture
    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_last_d = rsp_last_q;
        case (state_q)
            S_IDLE: begin
                if (cmdValid_i) begin
                    addr_d = cmdAddr_i;
                    data_d = cmdData_i;
                    cnt_d  = cmdLen_i;
                end
            end
            S_WRITE: begin
                if (cnt_zero) begin
                    rsp_data_d = 8'h00;
                    rsp_last_d = 1'b1;
                end else begin
                    addr_d = next_addr(addr_q);
                    cnt_d  = cnt_q - 13'd1;
                end
            end
            S_CAPTURE: begin
                rsp_data_d = busDataOut_i;
                rsp_last_d = cnt_zero;
            end
            S_RESP: begin
                if (rspReady_i && !cnt_zero) begin
                    addr_d = next_addr(addr_q);
                    cnt_d  = cnt_q - 13'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; bus address and write data come straight from flops
    always_ff @(posedge busClk_i or posedge busReset_i) begin
        if (busReset_i) begin
            addr_q     <= 14'd0;
            data_q     <= 8'd0;
            cnt_q      <= 13'd0;
            rsp_data_q <= 8'd0;
            rsp_last_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_last_q <= rsp_last_d;
        end
    end

    assign busAddr_o   = addr_q;
    assign busDataIn_o = data_q;
    assign rspData_o   = rsp_data_q;
    assign rspLast_o   = rsp_last_q;

endmodule

// File: tb/tb_anton_neopixel_bus_master.sv
// Directed bench for anton_neopixel_bus_master. A command-level model predicts
// every bus beat and every response. A per-cycle monitor checks the DUT
// against that model. Literal expectations pin the model itself.

module tb_anton_neopixel_bus_master;

    localparam logic [12:0] BE = 13'd1535;

    logic        busClk = 1'b0;
    logic        busReset;
    logic        cmdValid, cmdReady, cmdWrite;
    logic [13:0] cmdAddr;
    logic [7:0]  cmdData;
    logic [12:0] cmdLen;
    logic        rspValid, rspReady, rspLast;
    logic [7:0]  rspData;
    logic [13:0] busAddr;
    logic [7:0]  busDataIn, busDataOut;
    logic        busWrite, busRead, busy;

    anton_neopixel_bus_master #(.BUFFER_END(BE)) dut (
        .busClk_i     (busClk),
        .busReset_i   (busReset),
        .cmdValid_i   (cmdValid),
        .cmdReady_o   (cmdReady),
        .cmdWrite_i   (cmdWrite),
        .cmdAddr_i    (cmdAddr),
        .cmdData_i    (cmdData),
        .cmdLen_i     (cmdLen),
        .rspValid_o   (rspValid),
        .rspReady_i   (rspReady),
        .rspData_o    (rspData),
        .rspLast_o    (rspLast),
        .busAddr_o    (busAddr),
        .busDataIn_o  (busDataIn),
        .busWrite_o   (busWrite),
        .busRead_o    (busRead),
        .busDataOut_i (busDataOut),
        .busy_o       (busy)
    );

    always #5 busClk = ~busClk;

    typedef struct packed {
        logic        wr;
        logic [13:0] addr;
        logic [7:0]  data;
    } op_t;

    int n_err = 0;
    int n_checks = 0;

    op_t         exp_ops[$];
    logic [8:0]  exp_rsp[$];
    logic [13:0] obs_addr[$];
    logic [8:0]  obs_rsp[$];

    logic [7:0] resp_mem[16384];
    logic [7:0] model_mem[16384];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] model_next(input logic [13:0] a);
        int v;
        v = int'(a);
        if (v >= 8192) return 14'((v / 8) * 8 + ((v + 1) % 8));
        if (v == int'(BE)) return 14'd0;
        return 14'((v + 1) % 8192);
    endfunction

    // Expand one command into the beats and responses it must produce
    task automatic model_cmd(input logic wr, input logic [13:0] a0, input logic [7:0] d,
                             input logic [12:0] len);
        logic [13:0] a;
        a = a0;
        for (int i = 0; i <= int'(len); i++) begin
            if (wr) begin
                exp_ops.push_back('{1'b1, a, d});
                model_mem[a] = d;
            end else begin
                exp_ops.push_back('{1'b0, a, 8'h00});
                exp_rsp.push_back({(i == int'(len)), model_mem[a]});
            end
            a = model_next(a);
        end
        if (wr) exp_rsp.push_back(9'h100);
    endtask

    // Responder: read data appears only in the cycle after the read strobe
    logic        rd_pend = 1'b0;
    logic [13:0] rd_addr = 14'd0;
    always @(negedge busClk) begin
        if (rd_pend) busDataOut = resp_mem[rd_addr];
        else         busDataOut = 8'($urandom);
        rd_pend = busRead && !busReset;
        rd_addr = busAddr;
        if (busWrite && !busReset) resp_mem[busAddr] = busDataIn;
    end

    // Per-cycle compare against the model queues
    logic       prev_hold = 1'b0;
    logic [8:0] prev_rsp = 9'h0;
    always @(negedge busClk) begin
        if (busReset) begin
            prev_hold = 1'b0;
        end else begin
            chk("no_dual_strobe", {31'd0, busWrite & busRead}, 32'd0);
            chk("ready_vs_busy", {31'd0, cmdReady}, {31'd0, ~busy});
            if (!busy) chk("idle_quiet", {29'd0, busWrite, busRead, rspValid}, 32'd0);
            if (busWrite || busRead) begin
                obs_addr.push_back(busAddr);
                if (exp_ops.size() == 0) begin
                    chk("unexpected_strobe", {31'd0, busWrite | busRead}, 32'd0);
                end else begin
                    op_t e;
                    e = exp_ops.pop_front();
                    chk("op_kind", {31'd0, busWrite}, {31'd0, e.wr});
                    chk("op_addr", {18'd0, busAddr}, {18'd0, e.addr});
                    if (e.wr) chk("op_data", {24'd0, busDataIn}, {24'd0, e.data});
                end
            end
            if (prev_hold) begin
                chk("rsp_held_valid", {31'd0, rspValid}, 32'd1);
                chk("rsp_held_stable", {23'd0, rspLast, rspData}, {23'd0, prev_rsp});
            end
            if (rspValid && rspReady) begin
                obs_rsp.push_back({rspLast, rspData});
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", {31'd0, rspValid}, 32'd0);
                end else begin
                    logic [8:0] r;
                    r = exp_rsp.pop_front();
                    chk("rsp_value", {23'd0, rspLast, rspData}, {23'd0, r});
                end
            end
            prev_hold = rspValid && !rspReady;
            prev_rsp  = {rspLast, rspData};
        end
    end

    task automatic issue(input logic wr, input logic [13:0] a, input logic [7:0] d,
                         input logic [12:0] len);
        bit ok;
        ok = 0;
        @(posedge busClk); #1;
        cmdWrite = wr; cmdAddr = a; cmdData = d; cmdLen = len; cmdValid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge busClk);
            if (cmdReady) ok = 1;
            @(posedge busClk); #1;
        end
        cmdValid = 1'b0;
        cmdWrite = 1'($urandom);
        cmdAddr  = 14'($urandom);
        cmdData  = 8'($urandom);
        cmdLen   = 13'($urandom);
        if (!ok) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge busClk);
            if (!busy && exp_ops.size() == 0 && exp_rsp.size() == 0) done = 1;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_logs();
        obs_addr.delete();
        obs_rsp.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] la[4];
        logic [8:0]  lr[4];
        logic [8:0]  held;
        bit          seen;

        for (int i = 0; i < 16384; i++) begin
            resp_mem[i]  = 8'((i * 7 + 3) % 256);
            model_mem[i] = 8'((i * 7 + 3) % 256);
        end
        resp_mem[14'h2000] = 8'h34; model_mem[14'h2000] = 8'h34;
        resp_mem[14'h2001] = 8'h12; model_mem[14'h2001] = 8'h12;
        resp_mem[14'h2002] = 8'h04; model_mem[14'h2002] = 8'h04;
        resp_mem[14'h2003] = 8'h01; model_mem[14'h2003] = 8'h01;

        busReset = 1'b1; cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = 14'd0;
        cmdData = 8'd0; cmdLen = 13'd0; rspReady = 1'b1;
        repeat (3) @(posedge busClk);
        @(negedge busClk);
        chk("rst_rspValid", {31'd0, rspValid}, 32'd0);
        chk("rst_rspData", {24'd0, rspData}, 32'd0);
        chk("rst_rspLast", {31'd0, rspLast}, 32'd0);
        chk("rst_busWrite", {31'd0, busWrite}, 32'd0);
        chk("rst_busRead", {31'd0, busRead}, 32'd0);
        chk("rst_busAddr", {18'd0, busAddr}, 32'd0);
        chk("rst_busDataIn", {24'd0, busDataIn}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge busClk); #1 busReset = 1'b0;
        @(negedge busClk);
        chk("post_rst_cmdReady", {31'd0, cmdReady}, 32'd1);

        // Three-beat write from 0x0000, then one acknowledge
        clear_logs();
        model_cmd(1'b1, 14'h0000, 8'hAA, 13'd2);
        issue(1'b1, 14'h0000, 8'hAA, 13'd2);
        wait_done(100);
        la = '{14'h0000, 14'h0001, 14'h0002, 14'h0};
        chk("w3_count", obs_addr.size(), 32'd3);
        for (int i = 0; i < 3 && i < obs_addr.size(); i++) chk("w3_addr", {18'd0, obs_addr[i]}, {18'd0, la[i]});
        chk("w3_ack_count", obs_rsp.size(), 32'd1);
        if (obs_rsp.size() > 0) chk("w3_ack", {23'd0, obs_rsp[0]}, 32'h100);

        // Single write latency
        model_cmd(1'b1, 14'h0010, 8'h5A, 13'd0);
        issue(1'b1, 14'h0010, 8'h5A, 13'd0);
        @(negedge busClk);
        chk("lat_w_strobe", {31'd0, busWrite}, 32'd1);
        @(negedge busClk);
        chk("lat_w_rsp", {22'd0, rspValid, rspLast, rspData}, 32'h300);
        wait_done(100);

        // Single read latency, data written just before
        model_cmd(1'b0, 14'h0010, 8'h00, 13'd0);
        issue(1'b0, 14'h0010, 8'h00, 13'd0);
        @(negedge busClk);
        chk("lat_r_strobe", {31'd0, busRead}, 32'd1);
        @(negedge busClk);
        chk("lat_r_capture", {29'd0, busRead, busy, rspValid}, 32'd2);
        @(negedge busClk);
        chk("lat_r_rsp", {22'd0, rspValid, rspLast, rspData}, 32'h35A);
        wait_done(100);

        // Register read burst 0x2000 len 3
        clear_logs();
        model_cmd(1'b0, 14'h2000, 8'h00, 13'd3);
        issue(1'b0, 14'h2000, 8'h00, 13'd3);
        wait_done(200);
        lr = '{9'h034, 9'h012, 9'h004, 9'h101};
        chk("r37_count", obs_rsp.size(), 32'd4);
        for (int i = 0; i < 4 && i < obs_rsp.size(); i++) chk("r37_rsp", {23'd0, obs_rsp[i]}, {23'd0, lr[i]});

        // Write burst starting at BUFFER_END wraps to 0
        clear_logs();
        model_cmd(1'b1, {1'b0, BE}, 8'h3C, 13'd1);
        issue(1'b1, {1'b0, BE}, 8'h3C, 13'd1);
        wait_done(100);
        chk("w38_count", obs_addr.size(), 32'd2);
        if (obs_addr.size() == 2) begin
            chk("w38_addr0", {18'd0, obs_addr[0]}, 32'd1535);
            chk("w38_addr1", {18'd0, obs_addr[1]}, 32'd0);
        end

        // Register burst wraps within the 8-byte block
        clear_logs();
        model_cmd(1'b0, 14'h2006, 8'h00, 13'd3);
        issue(1'b0, 14'h2006, 8'h00, 13'd3);
        wait_done(200);
        la = '{14'h2006, 14'h2007, 14'h2000, 14'h2001};
        chk("r40_count", obs_addr.size(), 32'd4);
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) chk("r40_addr", {18'd0, obs_addr[i]}, {18'd0, la[i]});

        // Back-pressure: response held 5 cycles, no next read meanwhile
        clear_logs();
        @(posedge busClk); #1 rspReady = 1'b0;
        model_cmd(1'b0, 14'h0001, 8'h00, 13'd1);
        issue(1'b0, 14'h0001, 8'h00, 13'd1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge busClk);
            if (rspValid) seen = 1;
        end
        chk("bp_valid_seen", {31'd0, seen}, 32'd1);
        held = {rspLast, rspData};
        chk("bp_first_rsp", {23'd0, held}, 32'h0AA);
        repeat (5) begin
            @(negedge busClk);
            chk("bp_no_read", {31'd0, busRead}, 32'd0);
            chk("bp_stable", {22'd0, rspValid, rspLast, rspData}, {22'd0, 1'b1, held});
        end
        @(posedge busClk); #1 rspReady = 1'b1;
        wait_done(100);
        chk("bp_rsp_count", obs_rsp.size(), 32'd2);
        if (obs_rsp.size() == 2) chk("bp_second", {23'd0, obs_rsp[1]}, 32'h1AA);

        // Start above BUFFER_END counts up through 0x1FFF to 0x0000
        clear_logs();
        model_cmd(1'b1, 14'h1FFE, 8'h77, 13'd2);
        issue(1'b1, 14'h1FFE, 8'h77, 13'd2);
        wait_done(100);
        la = '{14'h1FFE, 14'h1FFF, 14'h0000, 14'h0};
        chk("hi_count", obs_addr.size(), 32'd3);
        for (int i = 0; i < 3 && i < obs_addr.size(); i++) chk("hi_addr", {18'd0, obs_addr[i]}, {18'd0, la[i]});

        // Maximum-length write burst
        clear_logs();
        model_cmd(1'b1, 14'h0100, 8'h11, 13'd8191);
        issue(1'b1, 14'h0100, 8'h11, 13'd8191);
        wait_done(9000);
        chk("max_beats", obs_addr.size(), 32'd8192);
        chk("max_acks", obs_rsp.size(), 32'd1);

        // Reset during beat 2 of a 4-beat write
        clear_logs();
        model_cmd(1'b1, 14'h0200, 8'h99, 13'd3);
        issue(1'b1, 14'h0200, 8'h99, 13'd3);
        @(posedge busClk); #3 busReset = 1'b1;
        #1;
        chk("mid_rst_strobe", {31'd0, busWrite}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rsp", {31'd0, rspValid}, 32'd0);
        exp_ops.delete();
        exp_rsp.delete();
        repeat (2) @(posedge busClk);
        #1 busReset = 1'b0;
        repeat (6) @(negedge busClk);
        chk("mid_rst_beats", obs_addr.size(), 32'd1);
        chk("mid_rst_no_ack", obs_rsp.size(), 32'd0);

        clear_logs();
        model_cmd(1'b0, 14'h2000, 8'h00, 13'd0);
        issue(1'b0, 14'h2000, 8'h00, 13'd0);
        wait_done(100);
        chk("after_rst_count", obs_rsp.size(), 32'd1);
        if (obs_rsp.size() == 1) chk("after_rst_rsp", {23'd0, obs_rsp[0]}, 32'h134);

        repeat (3) @(negedge busClk);
        chk("ops_left", exp_ops.size(), 32'd0);
        chk("rsp_left", exp_rsp.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
